// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_LEN    = 3'd2,
        ST_FETCH1 = 3'd3,
        ST_HOLD   = 3'd4
    } fetch_state_t;

    localparam logic [11:0] PC_RESET    = 12'h000;
    localparam logic [2:0]  INST_LEN_2W = 3'd2;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetches 1- or 2-word instructions from program ROM over a
//                req/ack handshake, asks the decoder for the instruction
//                length, and presents the assembled instruction with its PC
//                to execute over valid/ready. Supports PC redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] dec_op,
    input  logic [2:0]        dec_inst_len,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_word0,
    output logic [WORD_W-1:0] inst_word1,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_inst_pc;
    logic [WORD_W-1:0] r_word0;
    logic [WORD_W-1:0] r_word1;

    logic [PC_W-1:0]   w_pc_inc;

    // Natural wrap of the adder gives modulo-2^PC_W PC arithmetic.
    assign w_pc_inc = r_pc + PC_W'(1);

    // Handshake outputs are pure state decodes; address is parked at 0 when idle.
    assign rom_req    = (r_state == ST_FETCH0) || (r_state == ST_FETCH1);
    assign inst_valid = (r_state == ST_HOLD);
    assign rom_addr   = rom_req ? r_pc : '0;

    assign dec_op     = r_word0;
    assign inst_word0 = r_word0;
    assign inst_word1 = r_word1;
    assign inst_pc    = r_inst_pc;

    // Fetch sequencer: redirect overrides any pending ROM ack or handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= PC_W'(PC_RESET);
            r_inst_pc <= PC_W'(PC_RESET);
            r_word0   <= '0;
            r_word1   <= '0;
        end else if (r_state == ST_IDLE) begin
            r_state <= ST_FETCH0;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end
        end else if (redirect_valid) begin
            // Any in-flight ack is dropped: nothing captured, PC not advanced.
            r_state <= ST_FETCH0;
            r_pc    <= redirect_pc;
        end else begin
            case (r_state)
                ST_FETCH0: begin
                    if (rom_ack) begin
                        r_word0   <= rom_data;
                        r_word1   <= '0;
                        r_inst_pc <= r_pc;
                        r_pc      <= w_pc_inc;
                        r_state   <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    // Only an explicit 2-word length fetches an operand word.
                    if (dec_inst_len == INST_LEN_2W) begin
                        r_state <= ST_FETCH1;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_FETCH1: begin
                    if (rom_ack) begin
                        r_word1 <= rom_data;
                        r_pc    <= w_pc_inc;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        r_state <= ST_FETCH0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : instruction_fetch
`default_nettype wire
